// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 text controller.
package lcd_pkg;

  // HD44780 command bytes used by the controller
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no display shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, needs the long wait
  localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address 0x40

  // Top-level sequencing states
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_LINE1 = 3'd3,
    ST_ADDR2 = 3'd4,
    ST_LINE2 = 3'd5
  } top_state_e;

  // Byte-transfer engine states
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_SETUP = 2'd1,
    BUS_EHIGH = 2'd2,
    BUS_WAIT  = 2'd3
  } bus_state_e;

  // Init command table, index 0..3 in transmission order
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      2'd3:    cmd = LCD_CLEAR;
      default: cmd = LCD_FUNC_SET;
    endcase
    return cmd;
  endfunction

  // Character k of the 256-bit snapshot; char 0 is the most significant byte
  function automatic logic [7:0] snap_byte(input logic [255:0] snap, input logic [4:0] idx);
    logic [255:0] shifted;
    shifted = snap << {idx, 3'b000};
    return shifted[255:248];
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: setup, enable pulse, then a command-dependent wait.
// done pulses in the last wait cycle; done_pre_o is high the cycle before it so
// the sequencer can line up its own registered pulses with done.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int E_CYC   = 12,
  parameter int CMD_CYC = 1000,
  parameter int CLR_CYC = 41000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       done_pre_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam int WMAX = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int EW   = $clog2(E_CYC + 1);
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [EW-1:0] E_LAST   = EW'(E_CYC - 1);
  localparam logic [WW-1:0] CMD_LAST = WW'(CMD_CYC - 1);
  localparam logic [WW-1:0] CLR_LAST = WW'(CLR_CYC - 1);

  bus_state_e    state_q, state_d;
  logic [EW-1:0] e_cnt_q, e_cnt_d;
  logic [WW-1:0] w_cnt_q, w_cnt_d;
  logic          long_q, long_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic [WW-1:0] wait_last_s;

  // Transfer sequencing: latch byte, raise/lower enable, count the settle wait
  always_comb begin
    state_d     = state_q;
    e_cnt_d     = e_cnt_q;
    w_cnt_d     = w_cnt_q;
    long_d      = long_q;
    e_d         = e_q;
    rs_d        = rs_q;
    data_d      = data_q;
    done_d      = 1'b0;
    wait_last_s = long_q ? CLR_LAST : CMD_LAST;

    case (state_q)
      BUS_IDLE: begin
        if (start_i) begin
          state_d = BUS_SETUP;
          rs_d    = rs_i;
          data_d  = data_i;
          long_d  = long_wait_i;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_SETUP: begin
        state_d = BUS_EHIGH;
        e_d     = 1'b1;
        e_cnt_d = {EW{1'b0}};
      end
      BUS_EHIGH: begin
        if (e_cnt_q == E_LAST) begin
          state_d = BUS_WAIT;
          e_d     = 1'b0;
          w_cnt_d = {WW{1'b0}};
          done_d  = (wait_last_s == {WW{1'b0}});
        end else begin
          e_cnt_d = e_cnt_q + EW'(1);
        end
      end
      BUS_WAIT: begin
        if (w_cnt_q == wait_last_s) begin
          state_d = BUS_IDLE;
        end else begin
          w_cnt_d = w_cnt_q + WW'(1);
          done_d  = ((w_cnt_q + WW'(1)) == wait_last_s);
        end
      end
      default: begin
        state_d = BUS_IDLE;
        e_d     = 1'b0;
      end
    endcase
  end

  // Transfer engine registers; reset drops the enable strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      e_cnt_q <= {EW{1'b0}};
      w_cnt_q <= {WW{1'b0}};
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_cnt_q <= e_cnt_d;
      w_cnt_q <= w_cnt_d;
      long_q  <= long_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign done_o     = done_q;
  assign done_pre_o = done_d;
  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 16x2 text controller: power-up wait, one-time init, then endless
// refresh of both lines from a snapshot of the eight text words.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 500000,
  parameter int E_CYC     = 12,
  parameter int CMD_CYC   = 1000,
  parameter int CLR_CYC   = 41000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] textdata_a,
  input  logic [31:0] textdata_b,
  input  logic [31:0] textdata_c,
  input  logic [31:0] textdata_d,
  input  logic [31:0] textdata_e,
  input  logic [31:0] textdata_f,
  input  logic [31:0] textdata_g,
  input  logic [31:0] textdata_h,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        frame_done
);

  localparam int PW = $clog2(PWRUP_CYC + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);

  top_state_e    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [255:0]  snap_q, snap_d;
  logic          frame_done_q, frame_done_d;
  logic          rw_q;

  logic          start_s;
  logic          rs_s;
  logic [7:0]    data_s;
  logic          long_s;
  logic          advance_s;
  logic          bus_done_s;
  logic          bus_done_pre_s;

  // Sequencer: handshake with the bus engine, pick the next byte, take the snapshot
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    pwr_cnt_d    = pwr_cnt_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    start_s      = 1'b0;
    rs_s         = 1'b0;
    data_s       = 8'h00;
    long_s       = 1'b0;
    advance_s    = 1'b0;

    // A start is only issued while the engine is idle; the cycle after done
    // sees busy cleared and issues the next byte.
    if (state_q == ST_PWRUP) begin
      busy_d = 1'b0;
    end else if (!busy_q) begin
      start_s = 1'b1;
      busy_d  = 1'b1;
    end else if (bus_done_s) begin
      busy_d    = 1'b0;
      advance_s = 1'b1;
    end else begin
      busy_d = 1'b1;
    end

    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          state_d   = ST_INIT;
          pwr_cnt_d = {PW{1'b0}};
          idx_d     = 5'd0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PW'(1);
        end
      end
      ST_INIT: begin
        data_s = init_cmd(idx_q[1:0]);
        long_s = (idx_q[1:0] == 2'd3);
        if (advance_s) begin
          if (idx_q[1:0] == 2'd3) begin
            state_d = ST_ADDR1;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ADDR1: begin
        data_s = LCD_LINE1;
        if (start_s) begin
          snap_d = {textdata_a, textdata_b, textdata_c, textdata_d,
                    textdata_e, textdata_f, textdata_g, textdata_h};
        end else begin
          snap_d = snap_q;
        end
        if (advance_s) begin
          state_d = ST_LINE1;
          idx_d   = 5'd0;
        end else begin
          state_d = ST_ADDR1;
        end
      end
      ST_LINE1: begin
        rs_s   = 1'b1;
        data_s = snap_byte(snap_q, idx_q);
        if (advance_s) begin
          if (idx_q == 5'd15) begin
            state_d = ST_ADDR2;
          end else begin
            state_d = ST_LINE1;
          end
          idx_d = idx_q + 5'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ADDR2: begin
        data_s = LCD_LINE2;
        if (advance_s) begin
          state_d = ST_LINE2;
          idx_d   = 5'd16;
        end else begin
          state_d = ST_ADDR2;
        end
      end
      ST_LINE2: begin
        rs_s   = 1'b1;
        data_s = snap_byte(snap_q, idx_q);
        // Registered pulse lands in the same cycle the engine reports done
        if (busy_q && bus_done_pre_s && (idx_q == 5'd31)) begin
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = 1'b0;
        end
        if (advance_s) begin
          if (idx_q == 5'd31) begin
            state_d = ST_ADDR1;
            idx_d   = 5'd0;
          end else begin
            state_d = ST_LINE2;
            idx_d   = idx_q + 5'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d   = ST_PWRUP;
        idx_d     = 5'd0;
        busy_d    = 1'b0;
        pwr_cnt_d = {PW{1'b0}};
      end
    endcase
  end

  // Sequencer state, char index, snapshot and frame pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PWRUP;
      idx_q        <= 5'd0;
      busy_q       <= 1'b0;
      pwr_cnt_q    <= {PW{1'b0}};
      snap_q       <= {256{1'b0}};
      frame_done_q <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      pwr_cnt_q    <= pwr_cnt_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      rw_q         <= 1'b0;
    end
  end

  lcd_bus_cycle #(
    .E_CYC  (E_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC)
  ) u_bus (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_s),
    .rs_i       (rs_s),
    .data_i     (data_s),
    .long_wait_i(long_s),
    .done_o     (bus_done_s),
    .done_pre_o (bus_done_pre_s),
    .lcd_e_o    (lcd_e),
    .lcd_rs_o   (lcd_rs),
    .lcd_data_o (lcd_data)
  );

  assign lcd_rw     = rw_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Self-checking bench for lcd_text_ctrl with a schedule-based reference model.
module tb_lcd_text_ctrl;

  localparam int PWRUP = 20;
  localparam int ECYC  = 2;
  localparam int CMD   = 5;
  localparam int CLR   = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] tdw [8];
  logic        lcd_e, lcd_rs, lcd_rw, frame_done;
  logic [7:0]  lcd_data;

  int n_vec  = 0;
  int n_miss = 0;

  lcd_text_ctrl #(
    .PWRUP_CYC(PWRUP), .E_CYC(ECYC), .CMD_CYC(CMD), .CLR_CYC(CLR)
  ) dut (
    .clk(clk), .reset(reset),
    .textdata_a(tdw[0]), .textdata_b(tdw[1]), .textdata_c(tdw[2]), .textdata_d(tdw[3]),
    .textdata_e(tdw[4]), .textdata_f(tdw[5]), .textdata_g(tdw[6]), .textdata_h(tdw[7]),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte schedule, each transfer starting 2+E+W cycles after the previous one
  int          c;
  int          next_start;
  int          pos;
  bit          in_init;
  bit          have_cur;
  int          cur_start;
  int          cur_w;
  bit          cur_last;
  logic [8:0]  cur_b, prev_b;
  logic [7:0]  snap [32];
  logic [7:0]  init_tab [4];
  bit          prev_e;
  int          rise_c [$];
  logic [8:0]  rise_b [$];
  int          fall_c [$];
  int          fd_c [$];

  initial begin
    init_tab[0] = 8'h38; init_tab[1] = 8'h0C; init_tab[2] = 8'h06; init_tab[3] = 8'h01;
  end

  // Per-cycle compare against the model, plus recording of bus events
  always @(negedge clk) begin
    logic [11:0] exp_v, act_v;
    logic        exp_e, exp_fd;
    logic [8:0]  exp_b;
    logic [31:0] sh;
    act_v = {lcd_e, lcd_rw, lcd_rs, lcd_data, frame_done};
    if (reset) begin
      chk("reset_pins", 32'(act_v), 32'h0);
      c = 0; next_start = PWRUP; pos = 0; in_init = 1'b1; have_cur = 1'b0;
      cur_b = 9'h000; prev_b = 9'h000; cur_start = -100; cur_w = 0; cur_last = 1'b0;
      prev_e = 1'b0;
      rise_c.delete(); rise_b.delete(); fall_c.delete(); fd_c.delete();
    end else begin
      if (c == next_start) begin
        prev_b = cur_b;
        if (in_init) begin
          cur_b = {1'b0, init_tab[pos]};
          cur_w = (pos == 3) ? CLR : CMD;
          cur_last = 1'b0;
          pos++;
          if (pos == 4) begin in_init = 1'b0; pos = 0; end
        end else begin
          cur_w = CMD;
          cur_last = (pos == 33);
          if (pos == 0) begin
            for (int k = 0; k < 32; k++) begin
              sh = tdw[k/4] >> (8 * (3 - (k % 4)));
              snap[k] = sh[7:0];
            end
            cur_b = 9'h080;
          end else if (pos == 17) cur_b = 9'h0C0;
          else if (pos < 17) cur_b = {1'b1, snap[pos-1]};
          else cur_b = {1'b1, snap[pos-2]};
          pos = (pos + 1) % 34;
        end
        cur_start = c;
        next_start = c + 2 + ECYC + cur_w;
        have_cur = 1'b1;
      end
      exp_b  = (have_cur && c > cur_start) ? cur_b : prev_b;
      exp_e  = have_cur && (c >= cur_start + 2) && (c <= cur_start + 1 + ECYC);
      exp_fd = have_cur && cur_last && (c == cur_start + 1 + ECYC + cur_w);
      exp_v  = {exp_e, 1'b0, exp_b, exp_fd};
      chk("pins", 32'(act_v), 32'(exp_v));
      if (lcd_e && !prev_e) begin rise_c.push_back(c); rise_b.push_back({lcd_rs, lcd_data}); end
      if (!lcd_e && prev_e) fall_c.push_back(c);
      if (frame_done) fd_c.push_back(c);
      prev_e = lcd_e;
      c++;
    end
  end

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_c.size() < n && k < budget) begin @(posedge clk); k++; end
    chk("rise_timeout", 32'(rise_c.size() >= n), 32'h1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (fd_c.size() < n && k < budget) begin @(posedge clk); k++; end
    chk("frame_timeout", 32'(fd_c.size() >= n), 32'h1);
  endtask

  function automatic logic [8:0] wbyte(input logic [31:0] w, input int k);
    logic [31:0] sh;
    sh = w >> (8 * (3 - k));
    return {1'b1, sh[7:0]};
  endfunction

  logic [31:0] old_b, new_b;
  int          bad_cmds;
  int          wi;
  int          kk;

  initial begin
    tdw[0] = 32'h44_69_67_69;
    tdw[4] = 32'h31_32_3A_33;
    tdw[1] = $urandom; tdw[2] = $urandom; tdw[3] = $urandom;
    tdw[5] = $urandom; tdw[6] = $urandom; tdw[7] = $urandom;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Frame 1, char 2 (rise index 41): change textdata_b mid-frame
    wait_rises(42, 2000);
    @(posedge clk); #1;
    old_b = tdw[1];
    new_b = $urandom;
    if (new_b == old_b) new_b = ~old_b;
    tdw[1] = new_b;
    wait_frames(3, 1500);

    chk("first_rise_cycle", 32'(rise_c[0]), 32'd22);
    chk("first_rise_byte", 32'(rise_b[0]), 32'h038);
    chk("first_e_width", 32'(fall_c[0] - rise_c[0]), 32'd2);
    chk("init_b1", 32'(rise_b[1]), 32'h00C);
    chk("init_b2", 32'(rise_b[2]), 32'h006);
    chk("init_b3", 32'(rise_b[3]), 32'h001);
    chk("init_b4", 32'(rise_b[4]), 32'h080);
    chk("gap_38", 32'(fall_c[1] - fall_c[0]), 32'd9);
    chk("gap_0c", 32'(fall_c[2] - fall_c[1]), 32'd9);
    chk("gap_06", 32'(fall_c[3] - fall_c[2]), 32'd9);
    chk("gap_01", 32'(fall_c[4] - fall_c[3]), 32'd14);
    chk("line1_c0", 32'(rise_b[5]), 32'h144);
    chk("line1_c1", 32'(rise_b[6]), 32'h169);
    chk("line1_c2", 32'(rise_b[7]), 32'h167);
    chk("line1_c3", 32'(rise_b[8]), 32'h169);
    chk("addr2", 32'(rise_b[21]), 32'h0C0);
    chk("line2_c16", 32'(rise_b[22]), 32'h131);
    chk("line2_c17", 32'(rise_b[23]), 32'h132);
    chk("line2_c18", 32'(rise_b[24]), 32'h13A);
    chk("line2_c19", 32'(rise_b[25]), 32'h133);
    for (int k = 0; k < 4; k++) begin
      chk("snap_old_b", 32'(rise_b[43 + k]), 32'(wbyte(old_b, k)));
      chk("snap_new_b", 32'(rise_b[77 + k]), 32'(wbyte(new_b, k)));
    end
    chk("fd_spacing1", 32'(fd_c[1] - fd_c[0]), 32'd306);
    chk("fd_spacing2", 32'(fd_c[2] - fd_c[1]), 32'd306);
    bad_cmds = 0;
    for (int i = 5; i < rise_b.size(); i++)
      if (rise_b[i][8] == 1'b0 && rise_b[i] != 9'h080 && rise_b[i] != 9'h0C0) bad_cmds++;
    chk("no_reinit", 32'(bad_cmds), 32'd0);

    // Randomized text changes at random cycles
    repeat (900) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 39) == 0) begin
        wi = $urandom_range(0, 7);
        tdw[wi] = $urandom;
      end
    end

    // Reset while the enable strobe is high
    kk = 0;
    while (lcd_e !== 1'b1 && kk < 100) begin @(negedge clk); kk++; end
    chk("e_high_found", 32'(lcd_e), 32'h1);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done}), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_rises(1, 200);
    chk("rst_first_rise_cycle", 32'(rise_c[0]), 32'd22);
    chk("rst_first_rise_byte", 32'(rise_b[0]), 32'h038);
    wait_frames(1, 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
